// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single SRAM controller port: data side has fixed
// priority, and a starvation counter forces an instruction grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_r_en,
  input  logic              d_w_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I, DONE} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              if_rdy_q, if_rdy_d, d_rdy_q, d_rdy_d;
  logic              busy_q, busy_d;
  logic              d_pend;

  assign d_pend = d_r_en | d_w_en;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_rdy_d   = 1'b0;
    d_rdy_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pend && !(if_req && starve_q == LIM)) begin
          state_d  = GNT_D;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          // A simultaneous read+write request is treated as a write only.
          wr_d     = d_w_en;
          rd_d     = ~d_w_en;
          starve_d = !if_req ? 4'd0 : (starve_q == LIM) ? LIM : starve_q + 4'd1;
        end else if (if_req) begin
          state_d  = GNT_I;
          addr_d   = if_addr;
          wdata_d  = '0;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          starve_d = 4'd0;
        end
      end
      GNT_D, GNT_I: begin
        if (sram_ready) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          if (state_q == GNT_I) begin
            if_rdy_d   = 1'b1;
            if_rdata_d = sram_rdata;
          end else begin
            d_rdy_d = 1'b1;
            if (rd_q) d_rdata_d = sram_rdata;
          end
        end
      end
      // DONE always returns to IDLE so a requester's deassert is seen first.
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_rdy_q   <= 1'b0;
      d_rdy_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_rdy_q   <= if_rdy_d;
      d_rdy_q    <= d_rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_ready   = if_rdy_q;
  assign d_rdata    = d_rdata_q;
  assign d_ready    = d_rdy_q;
  assign sram_rd_en = rd_q;
  assign sram_wr_en = wr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: SRAM responder with programmable latency, directed
// scenarios and a randomized run checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;
  localparam int TN  = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, d_r_en = 1'b0, d_w_en = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] if_rdata, d_rdata, sram_wdata;
  logic [AW-1:0] sram_addr;
  logic          if_ready, d_ready, sram_rd_en, sram_wr_en, busy;
  logic [DW-1:0] sram_rdata;
  logic          sram_ready;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_r_en(d_r_en), .d_w_en(d_w_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // SRAM model: enables held for lat cycles (lat >= 2), ready in the last one.
  int          lat = 3;
  int          ecnt;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_val = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecnt       <= 0;
      sram_ready <= 1'b0;
      sram_rdata <= '0;
    end else begin
      sram_ready <= 1'b0;
      if ((sram_rd_en | sram_wr_en) && !sram_ready) begin
        if (ecnt >= lat - 2) begin
          sram_ready <= 1'b1;
          sram_rdata <= fixed_en ? fixed_val : hash(sram_addr);
          ecnt       <= 0;
        end else ecnt <= ecnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks += 3;
      if ((sram_rd_en & sram_wr_en) !== 1'b0) begin
        errors++; $display("FAIL enables_exclusive: rd=%b wr=%b, need not both", sram_rd_en, sram_wr_en);
      end
      if ((if_ready & d_ready) !== 1'b0) begin
        errors++; $display("FAIL ready_exclusive: if_ready=%b d_ready=%b, need not both", if_ready, d_ready);
      end
      if (((sram_rd_en | sram_wr_en) & (if_ready | d_ready)) !== 1'b0) begin
        errors++; $display("FAIL ready_enable_overlap: en=%b rdy=%b, need no overlap",
                           sram_rd_en | sram_wr_en, if_ready | d_ready);
      end
    end
  end

  logic          tr_rd[TN], tr_wr[TN], tr_ifr[TN], tr_dr[TN], tr_busy[TN], tr_srdy[TN];
  logic [AW-1:0] tr_addr[TN];
  logic [DW-1:0] tr_wdata[TN], tr_ifd[TN], tr_dd[TN];

  task automatic sample(input int i);
    @(negedge clk);
    tr_rd[i] = sram_rd_en;  tr_wr[i] = sram_wr_en;   tr_addr[i] = sram_addr;
    tr_wdata[i] = sram_wdata; tr_ifr[i] = if_ready;  tr_dr[i] = d_ready;
    tr_busy[i] = busy;      tr_srdy[i] = sram_ready; tr_ifd[i] = if_rdata;
    tr_dd[i] = d_rdata;
  endtask

  task automatic test_reset();
    logic [132:0] outs;
    bit seen = 1'b0;
    int pulses = 0, bsy = 0;
    outs = {if_rdata, if_ready, d_rdata, d_ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata, busy};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h need 0", outs); end
    @(negedge clk); rst = 1'b0;
    lat = 10; d_r_en = 1'b1; d_addr = 32'h40;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = sram_rd_en;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_setup_grant: rd_en=0 need 1 within 20 cycles"); end
    #2 rst = 1'b1;
    #1;
    outs = {if_rdata, if_ready, d_rdata, d_ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata, busy};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_async_mid_gnt: got %h need 0", outs); end
    d_r_en = 1'b0;
    @(negedge clk); rst = 1'b0; lat = 3;
    for (int i = 0; i < 10; i++) begin
      sample(i);
      pulses += int'(tr_ifr[i]) + int'(tr_dr[i]);
      bsy += int'(tr_busy[i]);
    end
    checks++;
    if (pulses != 0 || bsy != 0) begin
      errors++; $display("FAIL reset_release_quiet: ready pulses=%0d busy cycles=%0d need 0/0", pulses, bsy);
    end
  endtask

  task automatic test_lone_i();
    int nrd = 0, first = -1, s = -1, r = -1, nifr = 0;
    logic [31:0] got = '0;
    fixed_en = 1'b1; fixed_val = 32'hE3A01005; lat = 3;
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 20; i++) begin
      sample(i);
      if (tr_ifr[i]) if_req = 1'b0;
      if (tr_rd[i]) begin nrd++; if (first < 0) first = i; end
      if (tr_srdy[i] && s < 0) s = i;
      if (tr_ifr[i]) begin nifr++; r = i; got = tr_ifd[i]; end
    end
    fixed_en = 1'b0;
    checks += 6;
    if (first != 0) begin errors++; $display("FAIL lone_i_grant_latency: first rd idx %0d need 0", first); end
    if (nrd != 3) begin errors++; $display("FAIL lone_i_rd_cycles: got %0d need 3", nrd); end
    if (tr_addr[0] !== 32'h100) begin errors++; $display("FAIL lone_i_addr: got %h need 100", tr_addr[0]); end
    if (nifr != 1 || s < 0 || r != s + 1) begin
      errors++; $display("FAIL lone_i_ready: pulses=%0d at %0d (sram_ready %0d) need 1 at sram_ready+1", nifr, r, s);
    end
    if (got !== 32'hE3A01005) begin errors++; $display("FAIL lone_i_rdata: got %h need e3a01005", got); end
    if (s < 0 || s + 2 >= 20 || tr_busy[s+1] !== 1'b1 || tr_busy[s+2] !== 1'b0) begin
      errors++; $display("FAIL lone_i_busy: busy not high at sram_ready+1 and low at +2 (sram_ready %0d)", s);
    end
  endtask

  task automatic test_data_write(input bit both);
    int nrd = 0, nwr = 0, ndr = 0, first = -1;
    logic [31:0] prev, wd;
    logic [31:0] ad;
    prev = d_rdata;
    lat = $urandom_range(2, 5);
    ad = both ? 32'h480 : 32'h400;
    wd = both ? $urandom : 32'hDEADBEEF;
    d_w_en = 1'b1; d_r_en = both; d_addr = ad; d_wdata = wd;
    for (int i = 0; i < 20; i++) begin
      sample(i);
      if (tr_dr[i]) begin d_w_en = 1'b0; d_r_en = 1'b0; ndr++; end
      if (tr_rd[i]) nrd++;
      if (tr_wr[i]) begin nwr++; if (first < 0) first = i; end
    end
    checks += 5;
    if (nrd != 0) begin errors++; $display("FAIL wr%0d_rd_en: got %0d cycles need 0", both, nrd); end
    if (nwr != lat) begin errors++; $display("FAIL wr%0d_wr_cycles: got %0d need %0d", both, nwr, lat); end
    if (first != 0 || tr_addr[0] !== ad || tr_wdata[0] !== wd) begin
      errors++; $display("FAIL wr%0d_addr_data: idx %0d addr %h data %h need 0 %h %h",
                         both, first, tr_addr[0], tr_wdata[0], ad, wd);
    end
    if (ndr != 1) begin errors++; $display("FAIL wr%0d_d_ready: got %0d pulses need 1", both, ndr); end
    if (d_rdata !== prev) begin errors++; $display("FAIL wr%0d_rdata_kept: got %h need %h", both, d_rdata, prev); end
  endtask

  task automatic test_simultaneous();
    string got = "", exp = "";
    int cnt = 0;
    lat = 2;
    if_req = 1'b1; if_addr = 32'h1000; d_r_en = 1'b1; d_addr = 32'h2000;
    for (int i = 0; i < 60; i++) begin
      sample(i);
      if (tr_ifr[i]) got = {got, "I"};
      if (tr_dr[i])  got = {got, "D"};
    end
    if_req = 1'b0; d_r_en = 1'b0;
    repeat (8) @(negedge clk);
    for (int g = 0; g < 10; g++) begin
      if (cnt == LIM) begin exp = {exp, "I"}; cnt = 0; end
      else begin exp = {exp, "D"}; cnt = (cnt < LIM) ? cnt + 1 : LIM; end
    end
    checks++;
    if (got.len() < 10 || got.substr(0, 9) != exp) begin
      errors++; $display("FAIL simultaneous_order: got %s need prefix %s", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    int phase = 0, s1 = -1, j = -1, rises = 0, ndr = 0;
    logic [31:0] d2 = '0;
    lat = 3;
    d_r_en = 1'b1; d_addr = 32'h400;
    for (int i = 0; i < 40; i++) begin
      sample(i);
      if (tr_srdy[i] && s1 < 0) s1 = i;
      if (tr_rd[i] && (i == 0 || !tr_rd[i-1])) rises++;
      if (tr_rd[i] && tr_addr[i] === 32'h800 && j < 0) j = i;
      if (tr_dr[i]) begin ndr++; d2 = tr_dd[i]; end
      if (phase == 0 && tr_dr[i]) begin d_r_en = 1'b0; phase = 1; end
      else if (phase == 1) begin d_r_en = 1'b1; d_addr = 32'h800; phase = 2; end
      else if (phase == 2 && tr_dr[i]) begin d_r_en = 1'b0; phase = 3; end
    end
    checks += 4;
    if (rises != 2) begin errors++; $display("FAIL b2b_grants: got %0d grants need 2", rises); end
    if (s1 < 0 || j != s1 + 3) begin errors++; $display("FAIL b2b_turnaround: new addr at %0d need %0d", j, s1 + 3); end
    if (ndr != 2) begin errors++; $display("FAIL b2b_ready: got %0d pulses need 2", ndr); end
    if (d2 !== hash(32'h800)) begin errors++; $display("FAIL b2b_rdata: got %h need %h", d2, hash(32'h800)); end
  endtask

  task automatic test_random();
    int cnt = 0, grants = 0;
    bit prev_en = 1'b0, en, cur_d = 1'b0, cur_rd = 1'b0, win_d;
    logic [31:0] cur_addr = '0;
    bit sn_i = 1'b0, sn_d = 1'b0, sn_w = 1'b0;
    logic [31:0] sn_ia = '0, sn_da = '0, sn_wd = '0;
    for (int c = 0; c < 3000 && grants < 60; c++) begin
      @(negedge clk);
      en = sram_rd_en | sram_wr_en;
      if (en && !prev_en) begin
        checks++;
        if (!(sn_i || sn_d)) begin errors++; $display("FAIL rand_spurious_grant: addr %h with no request", sram_addr); end
        win_d = sn_d && !(sn_i && cnt == LIM);
        if (win_d) cnt = sn_i ? ((cnt < LIM) ? cnt + 1 : LIM) : 0;
        else cnt = 0;
        cur_d = win_d; cur_addr = win_d ? sn_da : sn_ia; cur_rd = !(win_d && sn_w);
        checks++;
        if (sram_rd_en !== cur_rd || sram_addr !== cur_addr || (!cur_rd && sram_wdata !== sn_wd)) begin
          errors++; $display("FAIL rand_grant %0d: rd=%b addr=%h wd=%h need rd=%b addr=%h wd=%h side=%s",
                             grants, sram_rd_en, sram_addr, sram_wdata, cur_rd, cur_addr, sn_wd, win_d ? "D" : "I");
        end
        grants++;
      end
      if (if_ready) begin
        checks++;
        if (cur_d || if_rdata !== hash(cur_addr)) begin
          errors++; $display("FAIL rand_if_ready: data %h side_d=%b need %h on I", if_rdata, cur_d, hash(cur_addr));
        end
        if_req = 1'b0; lat = $urandom_range(2, 5);
      end
      if (d_ready) begin
        checks++;
        if (!cur_d || (cur_rd && d_rdata !== hash(cur_addr))) begin
          errors++; $display("FAIL rand_d_ready: data %h side_d=%b need %h on D", d_rdata, cur_d, hash(cur_addr));
        end
        d_r_en = 1'b0; d_w_en = 1'b0; lat = $urandom_range(2, 5);
      end
      if (!if_req && !if_ready && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFC;
      end
      if (!(d_r_en | d_w_en) && !d_ready && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0: begin d_r_en = 1'b1; d_w_en = 1'b0; end
          1: begin d_r_en = 1'b0; d_w_en = 1'b1; end
          default: begin d_r_en = 1'b1; d_w_en = 1'b1; end
        endcase
        d_addr = 32'h10000 | ($urandom & 32'hFFFC); d_wdata = $urandom;
      end
      sn_i = if_req; sn_d = d_r_en | d_w_en; sn_w = d_w_en;
      sn_ia = if_addr; sn_da = d_addr; sn_wd = d_wdata;
      prev_en = en;
    end
    checks++;
    if (grants < 60) begin errors++; $display("FAIL rand_progress: got %0d grants need 60", grants); end
    if_req = 1'b0; d_r_en = 1'b0; d_w_en = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1;
    test_reset();
    test_lone_i();
    test_data_write(1'b0);
    test_data_write(1'b1);
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
